// File: rtl/vmask_pop_seq.sv
// Mask-register walker for vcpop.m / vfirst.m: fetches mask words, feeds the lane bit counter, accumulates popcount.
// Optional vfirst tracking is enabled by defining VMASK_POP_FIRST_EN.
module vmask_pop_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_VL     = 256,
  parameter int unsigned SBIT_CNT_B = $clog2(DATA_WIDTH),
  parameter int unsigned VL_B       = $clog2(MAX_VL) + 1,
  parameter int unsigned WADDR_B    = (MAX_VL / DATA_WIDTH > 1) ? $clog2(MAX_VL / DATA_WIDTH) : 1
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  input  logic                    start_i,
  input  logic [VL_B-1:0]         vl_i,
  output logic                    busy_o,
  output logic                    mask_req_o,
  output logic [WADDR_B-1:0]      mask_addr_o,
  input  logic                    mask_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mask_rdata_i,
  output logic [DATA_WIDTH-1:0]   cnt_data_o,
  output logic                    cnt_en_o,
  input  logic [SBIT_CNT_B:0]     cnt_i,
  output logic [VL_B-1:0]         result_o,
  output logic [VL_B-1:0]         first_o,
  output logic                    done_o
);

  localparam int unsigned DW_LOG = $clog2(DATA_WIDTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_COUNT = 3'd3;
  localparam logic [2:0] S_ACC   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            state_q,  state_d;
  logic                  busy_q,   busy_d;
  logic                  req_q,    req_d;
  logic                  en_q,     en_d;
  logic                  done_q,   done_d;
  logic [DATA_WIDTH-1:0] data_q,   data_d;
  logic [VL_B-1:0]       result_q, result_d;
  logic [VL_B-1:0]       acc_q,    acc_d;
  logic [WADDR_B-1:0]    idx_q,    idx_d;
  logic [WADDR_B-1:0]    last_q,   last_d;
  logic [DW_LOG-1:0]     rem_q,    rem_d;

  logic [VL_B-1:0]       vl_clip_c;
  logic [WADDR_B-1:0]    last_idx_c;
  logic                  last_word_c;
  logic [DATA_WIDTH-1:0] tail_c;
  logic [VL_B-1:0]       sum_c;

  // Start-time decode: clipped length and index of the final word
  assign vl_clip_c   = (vl_i > VL_B'(MAX_VL)) ? VL_B'(MAX_VL) : vl_i;
  assign last_idx_c  = WADDR_B'((vl_clip_c - VL_B'(1)) >> DW_LOG);
  assign last_word_c = (idx_q == last_q);
  assign sum_c       = acc_q + VL_B'(cnt_i);

  // Only the final word of a non-multiple length carries a partial tail
  always_comb begin
    tail_c = '1;
    if (last_word_c && (rem_q != '0)) begin
      tail_c = ~({DATA_WIDTH{1'b1}} << rem_q);
    end
  end

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    req_d    = 1'b0;
    en_d     = 1'b0;
    done_d   = 1'b0;
    data_d   = data_q;
    result_d = result_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    last_d   = last_q;
    rem_d    = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          busy_d = 1'b1;
          acc_d  = '0;
          idx_d  = '0;
          data_d = '0;
          last_d = last_idx_c;
          rem_d  = vl_clip_c[DW_LOG-1:0];
          if (vl_clip_c == '0) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = '0;
          end else begin
            state_d = S_FETCH;
            req_d   = 1'b1;
          end
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (mask_rvalid_i) begin
          data_d  = mask_rdata_i & tail_c;
          en_d    = 1'b1;
          state_d = S_COUNT;
        end
      end
      S_COUNT: state_d = S_ACC;
      S_ACC: begin
        acc_d = sum_c;
        if (last_word_c) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = sum_c;
        end else begin
          idx_d   = idx_q + WADDR_B'(1);
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      req_q    <= 1'b0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      result_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      last_q   <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      req_q    <= req_d;
      en_q     <= en_d;
      done_q   <= done_d;
      data_q   <= data_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      rem_q    <= rem_d;
    end
  end

  assign busy_o      = busy_q;
  assign mask_req_o  = req_q;
  assign mask_addr_o = idx_q;
  assign cnt_en_o    = en_q;
  assign cnt_data_o  = data_q;
  assign done_o      = done_q;
  assign result_o    = result_q;

`ifdef VMASK_POP_FIRST_EN
  logic [VL_B-1:0]   first_q, first_d;
  logic [VL_B-1:0]   fout_q,  fout_d;
  logic [DW_LOG-1:0] lsb_c;

  // Lowest set bit of the word currently presented to the counter
  always_comb begin
    lsb_c = '0;
    for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
      if (data_q[i]) lsb_c = DW_LOG'(i);
    end
  end

  always_comb begin
    first_d = first_q;
    fout_d  = fout_q;
    if ((state_q == S_IDLE) && start_i) begin
      first_d = '1;
      if (vl_clip_c == '0) fout_d = '1;
    end
    if ((state_q == S_COUNT) && (first_q == '1) && (data_q != '0)) begin
      first_d = VL_B'({idx_q, lsb_c});
    end
    if ((state_q == S_ACC) && last_word_c) fout_d = first_q;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      first_q <= '1;
      fout_q  <= '1;
    end else begin
      first_q <= first_d;
      fout_q  <= fout_d;
    end
  end

  assign first_o = fout_q;
`else
  assign first_o = '1;
`endif

endmodule

// File: tb/tb_vmask_pop_seq.sv
// Bench for vmask_pop_seq: table of mask-walk operations, a memory responder, a bit-counter model
// and a scoreboard of expected counter words; plus hand-written reset-abort sequence.
module tb_vmask_pop_seq;
  localparam int unsigned DW     = 32;
  localparam int unsigned MAX_VL = 256;
  localparam int unsigned SB     = $clog2(DW);
  localparam int unsigned VL_B   = $clog2(MAX_VL) + 1;
  localparam int unsigned WA     = $clog2(MAX_VL / DW);

  logic            clk_i;
  logic            resetn_i;
  logic            start_i;
  logic [VL_B-1:0] vl_i;
  logic            busy_o;
  logic            mask_req_o;
  logic [WA-1:0]   mask_addr_o;
  logic            mask_rvalid_i;
  logic [DW-1:0]   mask_rdata_i;
  logic [DW-1:0]   cnt_data_o;
  logic            cnt_en_o;
  logic [SB:0]     cnt_i;
  logic [VL_B-1:0] result_o;
  logic [VL_B-1:0] first_o;
  logic            done_o;

  vmask_pop_seq dut (
    .clk_i         (clk_i),
    .resetn_i      (resetn_i),
    .start_i       (start_i),
    .vl_i          (vl_i),
    .busy_o        (busy_o),
    .mask_req_o    (mask_req_o),
    .mask_addr_o   (mask_addr_o),
    .mask_rvalid_i (mask_rvalid_i),
    .mask_rdata_i  (mask_rdata_i),
    .cnt_data_o    (cnt_data_o),
    .cnt_en_o      (cnt_en_o),
    .cnt_i         (cnt_i),
    .result_o      (result_o),
    .first_o       (first_o),
    .done_o        (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Lane bit counter: latch transparent while clk high, popcount of the latched word
  logic [DW-1:0] cnt_lat;
  initial cnt_lat = '0;
  always @(negedge clk_i) if (cnt_en_o) cnt_lat <= cnt_data_o;
  assign cnt_i = (SB + 1)'($countones(cnt_lat));

  typedef struct {
    int                 vl;
    logic [7:0][31:0]   words;
    logic [7:0][3:0]    lat;
    int                 exp_res;
    logic [VL_B-1:0]    exp_first;
    bit                 mid_start;
  } vec_t;

  localparam int NVEC = 7;
  vec_t tbl [NVEC];
  logic [DW-1:0] exp_q [$];
  int n_vec;
  int n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] tail(input logic [DW-1:0] d, input int idx, input int vlc);
    int rem;
    int nw;
    logic [DW-1:0] m;
    rem = vlc % int'(DW);
    nw  = (vlc + int'(DW) - 1) / int'(DW);
    m   = '1;
    if (idx == nw - 1 && rem != 0) m = (32'd1 << rem) - 32'd1;
    return d & m;
  endfunction

  task automatic run_op(input vec_t v, input int rst_word);
    int vlc, nw, w, cd, cyc, exp_cyc, nreq;
    bit rst_pend, fin;
    logic [VL_B-1:0] efirst;
    logic [VL_B-1:0] res_seen;
    vlc = (v.vl > int'(MAX_VL)) ? int'(MAX_VL) : v.vl;
    nw  = (vlc + int'(DW) - 1) / int'(DW);
    exp_cyc = 2 + 4 * nw;
    for (int i = 0; i < nw; i++) exp_cyc += int'(v.lat[i]) - 1;
`ifdef VMASK_POP_FIRST_EN
    efirst = v.exp_first;
`else
    efirst = '1;
`endif
    w = 0; cd = 0; nreq = 0; cyc = 1; rst_pend = 0; fin = 0;
    res_seen = '0;
    exp_q.delete();
    start_i = 1'b1;
    vl_i    = VL_B'(v.vl);
    while (!fin) begin
      @(posedge clk_i); #1;
      cyc++;
      start_i = 1'b0;
      if (v.mid_start && cyc == 4) begin
        start_i = 1'b1;
        vl_i    = VL_B'(5);
      end
      if (rst_pend) begin
        resetn_i = 1'b0;
        mask_rvalid_i = 1'b0;
        #1;
        check("rst_busy",   64'(busy_o),     64'd0);
        check("rst_req",    64'(mask_req_o), 64'd0);
        check("rst_en",     64'(cnt_en_o),   64'd0);
        check("rst_cdata",  64'(cnt_data_o), 64'd0);
        check("rst_result", 64'(result_o),   64'd0);
        check("rst_first",  64'(first_o),    64'h1ff);
        repeat (3) begin
          @(posedge clk_i); #1;
          check("rst_no_done", 64'(done_o), 64'd0);
        end
        resetn_i = 1'b1;
        exp_q.delete();
        fin = 1;
      end else begin
        mask_rvalid_i = 1'b0;
        mask_rdata_i  = $urandom;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            mask_rvalid_i = 1'b1;
            mask_rdata_i  = v.words[w-1];
            exp_q.push_back(tail(v.words[w-1], w - 1, vlc));
          end
        end
        if (mask_req_o) begin
          check("mask_addr", 64'(mask_addr_o), 64'(w));
          cd = (w < 8) ? int'(v.lat[w]) : 1;
          if (w == rst_word) rst_pend = 1;
          w++;
          nreq++;
        end
        if (cnt_en_o) begin
          if (exp_q.size() == 0) check("cnt_en_unexpected", 64'd1, 64'd0);
          else check("cnt_data", 64'(cnt_data_o), 64'(exp_q.pop_front()));
        end
        if (done_o) begin
          check("result",  64'(result_o), 64'(v.exp_res));
          check("first",   64'(first_o),  64'(efirst));
          check("latency", 64'(cyc),      64'(exp_cyc));
          check("nreq",    64'(nreq),     64'(nw));
          check("busy_at_done", 64'(busy_o), 64'd1);
          res_seen = result_o;
          fin = 1;
        end
        if (cyc > 300) begin
          check("timeout", 64'd1, 64'd0);
          fin = 1;
        end
      end
    end
    if (rst_word < 0) begin
      mask_rvalid_i = 1'b0;
      @(posedge clk_i); #1;
      check("busy_after", 64'(busy_o),   64'd0);
      check("done_pulse", 64'(done_o),   64'd0);
      check("result_hold", 64'(result_o), 64'(res_seen));
    end
  endtask

  initial begin
    n_vec = 0; n_fail = 0;
    resetn_i = 1'b0; start_i = 1'b0; vl_i = '0;
    mask_rvalid_i = 1'b0; mask_rdata_i = '0;

    for (int i = 0; i < NVEC; i++) begin
      tbl[i].words = '0;
      tbl[i].lat   = {8{4'd1}};
      tbl[i].mid_start = 1'b0;
    end
    tbl[0].vl = 0;   tbl[0].exp_res = 0;  tbl[0].exp_first = '1;
    tbl[1].vl = 32;  tbl[1].words[0] = 32'hFFFF_FFFF;
    tbl[1].exp_res = 32; tbl[1].exp_first = 9'd0;
    tbl[2].vl = 40;  tbl[2].words[0] = 32'hFFFF_FFFF; tbl[2].words[1] = 32'hFFFF_FFFF;
    tbl[2].exp_res = 40; tbl[2].exp_first = 9'd0;
    tbl[3].vl = 70;  tbl[3].words[0] = 32'h0; tbl[3].words[1] = 32'h0001_0000;
    tbl[3].words[2] = 32'hFFFF_FFFF; tbl[3].lat[1] = 4'd3;
    tbl[3].exp_res = 7; tbl[3].exp_first = 9'd48;
    tbl[4].vl = 40;  tbl[4].words[0] = 32'h8000_0000; tbl[4].words[1] = 32'h0000_0100;
    tbl[4].exp_res = 1; tbl[4].exp_first = 9'd31; tbl[4].mid_start = 1'b1;
    tbl[5].vl = 300;
    for (int i = 1; i < 8; i++) tbl[5].words[i] = 32'd1 << i;
    tbl[5].exp_res = 7; tbl[5].exp_first = 9'd33;
    tbl[6].vl = 1;   tbl[6].words[0] = 32'hFFFF_FFFE;
    tbl[6].exp_res = 0; tbl[6].exp_first = '1;

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_busy",   64'(busy_o),     64'd0);
    check("reset_req",    64'(mask_req_o), 64'd0);
    check("reset_en",     64'(cnt_en_o),   64'd0);
    check("reset_done",   64'(done_o),     64'd0);
    check("reset_cdata",  64'(cnt_data_o), 64'd0);
    check("reset_result", 64'(result_o),   64'd0);
    check("reset_first",  64'(first_o),    64'h1ff);
    resetn_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < NVEC; i++) run_op(tbl[i], -1);

    // Abort in the WAIT of word 1, then a clean run afterwards
    run_op(tbl[3], 1);
    @(posedge clk_i); #1;
    run_op(tbl[1], -1);
    run_op(tbl[3], -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/vmask_pop_seq.md
Name: vmask_pop_seq

Overview:
- Sequencer that walks a vector mask register one DATA_WIDTH-bit word at a time for vcpop.m and vfirst.m.
- Sits directly upstream of the lane bit counter:
  - drives its data_i/enable_i with tail-masked mask words;
  - accumulates its sbit_cnt_o over all words;
  - reports total popcount and first-set index to the scalar writeback path.

Parameters:
- DATA_WIDTH, 32, mask word width; must match the bit counter.
- MAX_VL, 256, maximum vector length in elements (mask bits); multiple of DATA_WIDTH.
- SBIT_CNT_B, $clog2(DATA_WIDTH), bit-counter count width minus one.
- VL_B, $clog2(MAX_VL)+1, width of vl and result fields.
- WADDR_B, $clog2(MAX_VL/DATA_WIDTH), mask word address width (minimum 1).

Ports:
- clk_i  in  1  clock, rising edge.
- resetn_i  in  1  asynchronous active-low reset.
- start_i  in  1  start pulse; sampled only in IDLE.
- vl_i  in  VL_B  vector length, sampled with start_i; values above MAX_VL clipped to MAX_VL.
- busy_o  out  1  high from accepted start until done_o cycle inclusive.
- mask_req_o  out  1  mask word read request, one cycle per word.
- mask_addr_o  out  WADDR_B  word index of request.
- mask_rvalid_i  in  1  read data valid; latency of 1 or more cycles.
- mask_rdata_i  in  DATA_WIDTH  mask word.
- cnt_data_o  out  DATA_WIDTH  tail-masked word to bit counter data_i.
- cnt_en_o  out  1  to bit counter enable_i.
- cnt_i  in  SBIT_CNT_B+1  from bit counter sbit_cnt_o.
- result_o  out  VL_B  total popcount.
- first_o  out  VL_B  index of first set bit; all-ones if none.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset: async on resetn_i low.
  - FSM to IDLE.
  - busy_o, mask_req_o, cnt_en_o, done_o = 0; cnt_data_o = 0; result_o = 0; first_o = all-ones.
  - Reset mid-operation aborts with no done_o.
- FSM states IDLE, FETCH, WAIT, COUNT, ACC, DONE.
- IDLE:
  - start_i = 1: latch vl, clear accumulator to 0 and first to all-ones, word index = 0.
  - nwords = ceil(vl/DATA_WIDTH).
  - If vl == 0, go to DONE; else go to FETCH.
- FETCH: mask_req_o = 1 for exactly one cycle, mask_addr_o = word index, go to WAIT.
- WAIT: hold until mask_rvalid_i. Register masked word = mask_rdata_i AND tail mask, go to COUNT.
- Tail mask: all ones except on the last word when vl % DATA_WIDTH != 0; then bits >= vl % DATA_WIDTH are zeroed.
- COUNT:
  - cnt_data_o = masked word, cnt_en_o = 1 (one cycle; bit counter latch transparent while clk_i high).
  - If first is still all-ones and the word is nonzero, first = index*DATA_WIDTH + lowest set bit position.
  - Go to ACC.
- ACC:
  - cnt_en_o = 0; accumulator += cnt_i, zero-extended to VL_B.
  - If this was the last word, go to DONE; else increment word index and go to FETCH.
- cnt_data_o holds its last value outside COUNT; it is cleared only by reset or start.
- DONE:
  - result_o = accumulator, first_o = first, done_o = 1 for one cycle; go to IDLE.
  - result_o and first_o hold until the next accepted start.
- Latency: 4 cycles per word with 1-cycle read latency, plus 1 DONE cycle; vl = 0 completes in 2 cycles after start.
- start_i while busy is ignored, with no effect on the running operation.
- mask_rvalid_i outside WAIT is ignored.
- Accumulator cannot overflow: maximum MAX_VL fits in VL_B bits.

Optional Feature:
- VMASK_POP_FIRST_EN:
  - Defined: vfirst logic (priority encoder and first register) is present as described above.
  - Undefined: no priority encoder or first register; first_o is tied to all-ones at all times. Popcount path and timing are unchanged.

Test Plan:
- vl=0, start -> no mask_req_o; done_o 2 cycles after start; result_o=0; first_o=all-ones.
- vl=32, word0=0xFFFFFFFF -> one mask_req_o at addr 0; cnt_data_o=0xFFFFFFFF; result_o=32; first_o=0.
- vl=40, words 0xFFFFFFFF, 0xFFFFFFFF -> second cnt_data_o=0x000000FF; result_o=40; first_o=0.
- vl=70, words 0x0, 0x00010000, 0xFFFFFFFF, with rvalid delayed 3 cycles on word1:
  - cnt_data_o sequence 0x0, 0x00010000, 0x0000003F;
  - result_o=7, first_o=48.
- start_i pulsed again mid-run with vl=5 -> ignored; the original operation completes with unchanged result.
- resetn_i low during WAIT of word1 -> immediate IDLE, outputs at reset values, no done_o; a new start afterwards runs cleanly.
- Macro undefined, vl=70 case above -> result_o=7, first_o=all-ones.
